// File: rtl/value_ascii_streamer_pkg.sv
// Shared constants, FSM encoding and double-dabble step for value_ascii_streamer.
// VALUE_STREAM_CRLF_EN selects a CR+LF terminator; otherwise LF only.
package value_ascii_streamer_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  localparam int MAX_FRAME_LEN = 5;
  localparam int BCD_W         = 4;
  localparam int BCD_DIGITS    = 3;
  localparam int IDX_W         = $clog2(MAX_FRAME_LEN);

`ifdef VALUE_STREAM_CRLF_EN
  localparam int TERM_LEN = 2;
`else
  localparam int TERM_LEN = 1;
`endif
  localparam int FRAME_SLOTS = BCD_DIGITS + TERM_LEN;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  // One double-dabble iteration on {bcd[11:0], bin[7:0]}: add-3 then shift.
  function automatic logic [19:0] dd_step(input logic [19:0] sr);
    logic [19:0] t;
    t = sr;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (t[8 + i*BCD_W +: BCD_W] >= 4'd5)
        t[8 + i*BCD_W +: BCD_W] = t[8 + i*BCD_W +: BCD_W] + 4'd3;
    end
    return t << 1;
  endfunction

endpackage

// File: rtl/bin_to_bcd8.sv
// Sequential 8-bit binary to 3-digit BCD converter; the first iteration runs on
// the start edge, so o_done pulses seven cycles later with o_bcd final.
module bin_to_bcd8
  import value_ascii_streamer_pkg::*;
(
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [7:0]                    i_bin,
  output logic                          o_done,
  output logic [BCD_DIGITS*BCD_W-1:0]   o_bcd
);

  logic [19:0] sr_q, sr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        done_q, done_d;

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (i_start) begin
      sr_d  = dd_step({12'd0, i_bin});
      cnt_d = 3'd7;
    end else if (cnt_q != 3'd0) begin
      sr_d   = dd_step(sr_q);
      cnt_d  = cnt_q - 3'd1;
      done_d = (cnt_q == 3'd1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign o_done = done_q;
  assign o_bcd  = sr_q[19:8];

endmodule

// File: rtl/value_ascii_streamer.sv
// Streams the decimal ASCII text of i_value over valid/ready whenever it changes.
// Terminator is LF, or CR LF when VALUE_STREAM_CRLF_EN is defined.
//   state   | meaning
//   ST_IDLE | waiting for a stable value that differs from the last one sent
//   ST_CONV | bin_to_bcd8 running, frame built when it reports done
//   ST_SEND | presenting frame bytes, one per accepted handshake
module value_ascii_streamer
  import value_ascii_streamer_pkg::*;
#(
  parameter int LEADING_ZEROS = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_value,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_SLOTS - 1);

  state_e                        state_q, state_d;
  logic [7:0]                    s1_q, s1_d, s2_q, s2_d, last_q, last_d;
  logic [1:0]                    fill_q, fill_d;
  logic                          first_q, first_d;
  logic                          busy_q, busy_d, valid_q, valid_d;
  logic [7:0]                    data_q, data_d;
  logic [FRAME_SLOTS-1:0][7:0]   frame_q, frame_d, built;
  logic [IDX_W-1:0]              idx_q, idx_d, first_idx;
  logic                          stable, start, bcd_done;
  logic [BCD_DIGITS*BCD_W-1:0]   bcd;

  bin_to_bcd8 u_bcd (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (start),
    .i_bin   (s2_q),
    .o_done  (bcd_done),
    .o_bcd   (bcd)
  );

  // fill_q keeps the reset-zero sync registers from looking like a real sample.
  assign stable = fill_q[1] && (s1_q == s2_q);

  always_comb begin
    built[0] = ASCII_ZERO + {4'd0, bcd[11:8]};
    built[1] = ASCII_ZERO + {4'd0, bcd[7:4]};
    built[2] = ASCII_ZERO + {4'd0, bcd[3:0]};
`ifdef VALUE_STREAM_CRLF_EN
    built[3] = ASCII_CR;
    built[4] = ASCII_LF;
`else
    built[3] = ASCII_LF;
`endif
    if (LEADING_ZEROS != 0 || bcd[11:8] != 4'd0) first_idx = IDX_W'(0);
    else if (bcd[7:4] != 4'd0)                   first_idx = IDX_W'(1);
    else                                         first_idx = IDX_W'(2);
  end

  always_comb begin
    state_d = state_q;
    s1_d    = i_value;
    s2_d    = s1_q;
    fill_d  = {fill_q[0], 1'b1};
    last_d  = last_q;
    first_d = first_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    data_d  = data_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stable && (first_q || s2_q != last_q)) begin
          last_d  = s2_q;
          first_d = 1'b0;
          start   = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        if (bcd_done) begin
          frame_d = built;
          idx_d   = first_idx;
          data_d  = built[first_idx];
          valid_d = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (valid_q && i_ready) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            data_d  = 8'h00;
            state_d = ST_IDLE;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            data_d = frame_q[idx_q + IDX_W'(1)];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      s1_q    <= '0;
      s2_q    <= '0;
      fill_q  <= '0;
      last_q  <= '0;
      first_q <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      frame_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      fill_q  <= fill_d;
      last_q  <= last_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_value_ascii_streamer.sv
// Scoreboard bench: two instances (leading zeros on/off) share stimulus; expected
// frames are queued at stimulus time and popped by a negedge monitor on each transfer.
module tb_value_ascii_streamer;

  logic       clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_value;
  logic       i_ready;
  logic [7:0] d0, d1;
  logic       v0, v1, busy0, busy1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  logic       hold_p[2];
  logic [7:0] hold_d[2];

  always #5 clk = ~clk;

  value_ascii_streamer #(.LEADING_ZEROS(1)) u_dut_lz (
    .i_clk(clk), .i_rst(i_rst), .i_value(i_value), .i_ready(i_ready),
    .o_data(d0), .o_valid(v0), .o_busy(busy0)
  );

  value_ascii_streamer #(.LEADING_ZEROS(0)) u_dut_nz (
    .i_clk(clk), .i_rst(i_rst), .i_value(i_value), .i_ready(i_ready),
    .o_data(d1), .o_valid(v1), .o_busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_frame(input int v);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    exp0.push_back(8'(48 + h));
    exp0.push_back(8'(48 + t));
    exp0.push_back(8'(48 + u));
    if (h != 0) exp1.push_back(8'(48 + h));
    if (h != 0 || t != 0) exp1.push_back(8'(48 + t));
    exp1.push_back(8'(48 + u));
`ifdef VALUE_STREAM_CRLF_EN
    exp0.push_back(8'h0D);
    exp1.push_back(8'h0D);
`endif
    exp0.push_back(8'h0A);
    exp1.push_back(8'h0A);
  endtask

  task automatic mon(input int ch, input logic v, input logic [7:0] d);
    logic [7:0] e;
    logic       empty;
    if (v) begin
      if (hold_p[ch]) check($sformatf("hold_data%0d", ch), d, hold_d[ch]);
      if (i_ready) begin
        empty = 1'b0;
        e = 8'h00;
        if (ch == 0) begin
          if (exp0.size() == 0) empty = 1'b1; else e = exp0.pop_front();
        end else begin
          if (exp1.size() == 0) empty = 1'b1; else e = exp1.pop_front();
        end
        if (empty) begin
          n_checks++;
          $display("FAIL unexpected_byte%0d: got %0h expected no transfer", ch, d);
        end else begin
          check($sformatf("byte%0d", ch), d, e);
        end
      end
      hold_p[ch] = !i_ready;
      hold_d[ch] = d;
    end else begin
      if (hold_p[ch]) check($sformatf("valid_dropped%0d", ch), 0, 1);
      hold_p[ch] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (i_rst) begin
      hold_p[0] = 1'b0;
      hold_p[1] = 1'b0;
    end else begin
      mon(0, v0, d0);
      mon(1, v1, d1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp0.size() != 0 || exp1.size() != 0 || busy0 || busy1) && n < 500) begin
      cyc();
      n++;
    end
    if (n >= 500) check({name, "_timeout"}, n, 0);
  endtask

  task automatic valid_latency(input string name);
    int k;
    for (k = 0; k < 30; k++) begin
      cyc();
      if (v0) break;
    end
    check(name, k, 10);
  endtask

  initial begin
    int n;
    hold_p[0] = 1'b0;
    hold_p[1] = 1'b0;
    i_rst   = 1'b1;
    i_value = 8'd0;
    i_ready = 1'b1;
    repeat (3) cyc();
    check("rst_valid0", v0, 0);
    check("rst_valid1", v1, 0);
    check("rst_data0", d0, 8'h00);
    check("rst_data1", d1, 8'h00);
    check("rst_busy0", busy0, 0);
    check("rst_busy1", busy1, 0);

    push_frame(0);
    i_rst = 1'b0;
    valid_latency("lat_after_reset");
    wait_idle("first_frame");

    i_value = 8'd123;
    push_frame(123);
    valid_latency("lat_123");
    n = 0;
    while (v0 && n < 20) begin
      cyc();
      n++;
    end
    check("b2b_len_123", n, 4 + `ifdef VALUE_STREAM_CRLF_EN 1 `else 0 `endif);
    wait_idle("frame_123");
    check("busy_after0", busy0, 0);
    check("busy_after1", busy1, 0);

    i_ready = 1'b0;
    i_value = 8'd200;
    push_frame(200);
    n = 0;
    while (!v0 && n < 40) begin
      cyc();
      n++;
    end
    check("stall_valid_seen", v0, 1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("stall_data", d0, 8'h32);
      check("stall_valid", v0, 1);
    end
    i_ready = 1'b1;
    wait_idle("frame_200");

    i_value = 8'd255;
    push_frame(255);
    wait_idle("frame_255");
    i_value = 8'd0;
    push_frame(0);
    wait_idle("frame_wrap");

    i_value = 8'd1;
    push_frame(1);
    n = 0;
    while (!busy0 && n < 20) begin
      cyc();
      n++;
    end
    check("busy_seen_1", busy0, 1);
    repeat (3) cyc();
    i_value = 8'd2;
    repeat (3) cyc();
    i_value = 8'd3;
    push_frame(3);
    wait_idle("frame_003");

    repeat (30) cyc();
    check("no_resend0", busy0, 0);
    check("no_resend1", busy1, 0);

    i_value = 8'd45;
    push_frame(45);
    n = 0;
    while (exp0.size() > 3 && n < 100) begin
      cyc();
      n++;
    end
    check("reached_byte2", exp0.size(), 3);
    i_rst = 1'b1;
    cyc();
    check("midrst_valid0", v0, 0);
    check("midrst_valid1", v1, 0);
    check("midrst_busy0", busy0, 0);
    check("midrst_data0", d0, 8'h00);
    exp0.delete();
    exp1.delete();
    push_frame(45);
    i_rst = 1'b0;
    wait_idle("frame_045_resend");

    i_value = 8'd7;
    push_frame(7);
    wait_idle("frame_7");
    i_value = 8'd0;
    push_frame(0);
    wait_idle("frame_0");
    i_value = 8'd100;
    push_frame(100);
    wait_idle("frame_100");

    repeat (5) cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
